// File: rtl/wbgen2_dpssram_arb_pkg.sv
// Shared definitions for the dual-port SRAM port arbiter: index sizing and
// the read-return tag layout.
package wbgen2_dpssram_arb_pkg;

    localparam int c_max_masters = 8;

    function automatic int f_log2_ceil(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    localparam int c_tag_idx_w = f_log2_ceil(c_max_masters);

    typedef struct packed {
        logic                   valid;
        logic [c_tag_idx_w-1:0] idx;
    } t_read_tag;

endpackage

// File: rtl/wbgen2_rr_arbiter.sv
// Round-robin picker: the first request after the last winner wins, and the
// last winner only moves when an accept actually happens.
module wbgen2_rr_arbiter
    import wbgen2_dpssram_arb_pkg::*;
#(
    parameter  int g_num = 2,
    localparam int c_iw  = f_log2_ceil(g_num)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [g_num-1:0] req_i,
    input  logic             en_i,
    output logic [g_num-1:0] grant_o,
    output logic [c_iw-1:0]  idx_o,
    output logic             valid_o
);

    logic [c_iw-1:0] last_grant_q, last_grant_d;
    logic            found;
    logic [c_iw-1:0] cand;

    always_comb begin
        found = 1'b0;
        cand  = '0;
        // Scan offsets 1..N from the last winner so the winner itself is tried last.
        for (int k = 1; k <= g_num; k++) begin
            for (int i = 0; i < g_num; i++) begin
                if (!found && req_i[i] && (i == (int'(last_grant_q) + k) % g_num)) begin
                    found = 1'b1;
                    cand  = c_iw'(i);
                end
            end
        end
        valid_o = found & en_i;
        idx_o   = cand;
        grant_o = '0;
        for (int i = 0; i < g_num; i++) begin
            grant_o[i] = valid_o && (cand == c_iw'(i));
        end
        last_grant_d = valid_o ? cand : last_grant_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_grant_q <= c_iw'(g_num - 1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/wbgen2_dpssram_arbiter.sv
// Shares one SRAM port between several requesters: registers the winning
// request onto the RAM port and steers read data back two cycles later.
module wbgen2_dpssram_arbiter
    import wbgen2_dpssram_arb_pkg::*;
#(
    parameter  int g_num_masters = 2,
    parameter  int g_data_width  = 32,
    parameter  int g_addr_width  = 10,
    localparam int c_bw          = (g_data_width + 7) / 8,
    localparam int c_iw          = f_log2_ceil(g_num_masters)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_n_i,
    input  logic [g_num_masters-1:0]              m_req_i,
    input  logic [g_num_masters-1:0]              m_we_i,
    input  logic [g_num_masters*g_addr_width-1:0] m_addr_i,
    input  logic [g_num_masters*g_data_width-1:0] m_data_i,
    input  logic [g_num_masters*c_bw-1:0]         m_bwsel_i,
    output logic [g_num_masters-1:0]              m_ack_o,
    output logic [g_num_masters-1:0]              m_rvalid_o,
    output logic [g_data_width-1:0]               m_rdata_o,
    output logic [g_addr_width-1:0]               ram_addr_o,
    output logic [g_data_width-1:0]               ram_data_o,
    output logic [c_bw-1:0]                       ram_bwsel_o,
    output logic                                  ram_rd_o,
    output logic                                  ram_wr_o,
    input  logic [g_data_width-1:0]               ram_data_i
);

    logic [g_num_masters-1:0] grant;
    logic [c_iw-1:0]          grant_idx;
    logic                     accept;

    logic                     sel_we;
    logic [g_addr_width-1:0]  sel_addr;
    logic [g_data_width-1:0]  sel_data;
    logic [c_bw-1:0]          sel_bw;

    logic [g_addr_width-1:0]  ram_addr_q, ram_addr_d;
    logic [g_data_width-1:0]  ram_data_q, ram_data_d;
    logic [c_bw-1:0]          ram_bwsel_q, ram_bwsel_d;
    logic                     ram_rd_q, ram_rd_d;
    logic                     ram_wr_q, ram_wr_d;
    t_read_tag                tag_s1_q, tag_s1_d;
    t_read_tag                tag_s2_q, tag_s2_d;

    // Accepting is disabled while reset is held so no ack leaks out.
    wbgen2_rr_arbiter #(
        .g_num (g_num_masters)
    ) u_rr (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .req_i   (m_req_i),
        .en_i    (rst_n_i),
        .grant_o (grant),
        .idx_o   (grant_idx),
        .valid_o (accept)
    );

    assign m_ack_o = grant;

    always_comb begin
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        sel_bw   = '0;
        for (int i = 0; i < g_num_masters; i++) begin
            if (grant_idx == c_iw'(i)) begin
                sel_we   = m_we_i[i];
                sel_addr = m_addr_i[i*g_addr_width +: g_addr_width];
                sel_data = m_data_i[i*g_data_width +: g_data_width];
                sel_bw   = m_bwsel_i[i*c_bw +: c_bw];
            end
        end
    end

    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_data_d  = ram_data_q;
        ram_bwsel_d = ram_bwsel_q;
        ram_rd_d    = 1'b0;
        ram_wr_d    = 1'b0;
        tag_s1_d    = '0;
        if (accept) begin
            ram_addr_d     = sel_addr;
            ram_data_d     = sel_data;
            ram_bwsel_d    = sel_bw;
            ram_rd_d       = !sel_we;
            ram_wr_d       = sel_we;
            tag_s1_d.valid = !sel_we;
            tag_s1_d.idx   = c_tag_idx_w'(grant_idx);
        end
        // Second stage lines up with the RAM's registered read data.
        tag_s2_d = tag_s1_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
            ram_bwsel_q <= '0;
            ram_rd_q    <= 1'b0;
            ram_wr_q    <= 1'b0;
            tag_s1_q    <= '0;
            tag_s2_q    <= '0;
        end else begin
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
            ram_bwsel_q <= ram_bwsel_d;
            ram_rd_q    <= ram_rd_d;
            ram_wr_q    <= ram_wr_d;
            tag_s1_q    <= tag_s1_d;
            tag_s2_q    <= tag_s2_d;
        end
    end

    always_comb begin
        m_rvalid_o = '0;
        for (int i = 0; i < g_num_masters; i++) begin
            m_rvalid_o[i] = tag_s2_q.valid && (tag_s2_q.idx == c_tag_idx_w'(i));
        end
    end

    assign m_rdata_o   = ram_data_i;
    assign ram_addr_o  = ram_addr_q;
    assign ram_data_o  = ram_data_q;
    assign ram_bwsel_o = ram_bwsel_q;
    assign ram_rd_o    = ram_rd_q;
    assign ram_wr_o    = ram_wr_q;

endmodule

// File: tb/tb_wbgen2_dpssram_arbiter.sv
// Self-checking bench for wbgen2_dpssram_arbiter: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_wbgen2_dpssram_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int BW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    m_req, m_we;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_data;
    logic [N*BW-1:0] m_bwsel;
    logic [N-1:0]    m_ack_o, m_rvalid_o;
    logic [DW-1:0]   m_rdata_o;
    logic [AW-1:0]   ram_addr_o;
    logic [DW-1:0]   ram_data_o;
    logic [BW-1:0]   ram_bwsel_o;
    logic            ram_rd_o, ram_wr_o;
    logic [DW-1:0]   ram_rdata;

    wbgen2_dpssram_arbiter #(
        .g_num_masters (N),
        .g_data_width  (DW),
        .g_addr_width  (AW)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .m_req_i     (m_req),
        .m_we_i      (m_we),
        .m_addr_i    (m_addr),
        .m_data_i    (m_data),
        .m_bwsel_i   (m_bwsel),
        .m_ack_o     (m_ack_o),
        .m_rvalid_o  (m_rvalid_o),
        .m_rdata_o   (m_rdata_o),
        .ram_addr_o  (ram_addr_o),
        .ram_data_o  (ram_data_o),
        .ram_bwsel_o (ram_bwsel_o),
        .ram_rd_o    (ram_rd_o),
        .ram_wr_o    (ram_wr_o),
        .ram_data_i  (ram_rdata)
    );

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                            input logic [DW-1:0] new_v,
                                            input logic [BW-1:0] bw);
        logic [DW-1:0] r;
        r = old_v;
        for (int b = 0; b < BW; b++) if (bw[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        return r;
    endfunction

    // Single-port RAM with registered read.
    bit [DW-1:0] ram_mem [1<<AW];
    always @(posedge clk) begin
        if (ram_wr_o) ram_mem[ram_addr_o] <= merge(ram_mem[ram_addr_o], ram_data_o, ram_bwsel_o);
        if (ram_rd_o) ram_rdata <= ram_mem[ram_addr_o];
    end

    // Reference model state
    logic          p_req [N];
    logic          p_we  [N];
    logic [AW-1:0] p_addr[N];
    logic [DW-1:0] p_data[N];
    logic [BW-1:0] p_bw  [N];
    bit   [DW-1:0] gold  [1<<AW];
    int            last_g;
    logic          e_rd, e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic [BW-1:0] e_bw;

    typedef struct {
        int            due;
        int            m;
        logic [DW-1:0] d;
    } rd_t;
    rd_t exp_q[$];

    int            cyc;
    int            winner;
    bit            keep_req;
    logic [N-1:0]  seen_rvalid;
    logic [DW-1:0] seen_rdata;
    int            n_checks = 0;
    int            n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic int rr_pick();
        for (int k = 1; k <= N; k++) begin
            if (p_req[(last_g + k) % N]) return (last_g + k) % N;
        end
        return -1;
    endfunction

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            m_req[i]              = p_req[i];
            m_we[i]               = p_we[i];
            m_addr[i*AW +: AW]    = p_addr[i];
            m_data[i*DW +: DW]    = p_data[i];
            m_bwsel[i*BW +: BW]   = p_bw[i];
        end
    endtask

    task automatic set_req(input int m, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [BW-1:0] bw);
        p_req[m] = 1'b1; p_we[m] = we; p_addr[m] = a; p_data[m] = d; p_bw[m] = bw;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) p_req[i] = 1'b0;
    endtask

    task automatic step();
        logic [N-1:0] exp_ack, exp_rv;
        rd_t r;
        @(posedge clk);
        #1;
        apply();
        @(negedge clk);
        winner  = rr_pick();
        exp_ack = '0;
        if (winner >= 0) exp_ack[winner] = 1'b1;
        check("ack", 64'(m_ack_o), 64'(exp_ack));
        check("ram_rd", 64'(ram_rd_o), 64'(e_rd));
        check("ram_wr", 64'(ram_wr_o), 64'(e_wr));
        check("ram_addr", 64'(ram_addr_o), 64'(e_addr));
        check("ram_data", 64'(ram_data_o), 64'(e_data));
        check("ram_bwsel", 64'(ram_bwsel_o), 64'(e_bw));
        exp_rv = '0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            r = exp_q.pop_front();
            exp_rv[r.m] = 1'b1;
            check("rdata", 64'(m_rdata_o), 64'(r.d));
        end
        check("rvalid", 64'(m_rvalid_o), 64'(exp_rv));
        seen_rvalid = m_rvalid_o;
        seen_rdata  = m_rdata_o;
        e_rd = 1'b0;
        e_wr = 1'b0;
        if (winner >= 0) begin
            last_g = winner;
            e_addr = p_addr[winner];
            e_data = p_data[winner];
            e_bw   = p_bw[winner];
            e_rd   = !p_we[winner];
            e_wr   = p_we[winner];
            if (p_we[winner]) begin
                gold[p_addr[winner]] = merge(gold[p_addr[winner]], p_data[winner], p_bw[winner]);
            end else begin
                r.due = cyc + 2;
                r.m   = winner;
                r.d   = gold[p_addr[winner]];
                exp_q.push_back(r);
            end
            if (!keep_req) p_req[winner] = 1'b0;
        end
        cyc++;
    endtask

    task automatic do_reset(input int ncyc);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        m_req = '1;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            check("rst_ack", 64'(m_ack_o), 64'd0);
            check("rst_rd", 64'(ram_rd_o), 64'd0);
            check("rst_wr", 64'(ram_wr_o), 64'd0);
            check("rst_rvalid", 64'(m_rvalid_o), 64'd0);
            check("rst_addr", 64'(ram_addr_o), 64'd0);
            check("rst_data", 64'(ram_data_o), 64'd0);
        end
        clear_reqs();
        apply();
        rst_n  = 1'b1;
        last_g = N - 1;
        e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_data = '0; e_bw = '0;
        exp_q.delete();
    endtask

    initial begin
        cyc = 0;
        keep_req = 1'b0;
        for (int i = 0; i < N; i++) begin
            p_req[i] = 1'b0; p_we[i] = 1'b0; p_addr[i] = '0; p_data[i] = '0; p_bw[i] = '0;
        end
        apply();
        do_reset(3);

        // Round robin with all masters requesting continuously.
        keep_req = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i), '0, '0);
        for (int i = 0; i < 12; i++) begin
            step();
            check("rr_seq", 64'(winner), 64'(i % N));
        end
        keep_req = 1'b0;
        clear_reqs();
        step(); step(); step();

        // Rotation skip from last_grant = 1.
        set_req(1, 1'b0, 10'h001, '0, '0);
        step();
        check("skip_setup", 64'(winner), 64'd1);
        set_req(0, 1'b0, 10'h002, '0, '0);
        set_req(3, 1'b0, 10'h003, '0, '0);
        step();
        check("skip_first", 64'(winner), 64'd3);
        step();
        check("skip_second", 64'(winner), 64'd0);
        step(); step();

        // Write then read by master 1.
        set_req(1, 1'b1, 10'h005, 32'hDEADBEEF, 4'hF);
        step();
        check("wtr_wr_ack", 64'(winner), 64'd1);
        set_req(1, 1'b0, 10'h005, '0, '0);
        step();
        check("wtr_rd_ack", 64'(winner), 64'd1);
        check("wtr_wr_strobe", 64'(ram_wr_o), 64'd1);
        step();
        check("wtr_rv_early", 64'(seen_rvalid), 64'd0);
        step();
        check("wtr_rvalid", 64'(seen_rvalid), 64'b0010);
        check("wtr_rdata", 64'(seen_rdata), 64'hDEADBEEF);

        // Interleaved reads from masters 0 and 2.
        set_req(0, 1'b1, 10'h010, 32'h11, 4'hF);
        step();
        set_req(2, 1'b1, 10'h020, 32'h22, 4'hF);
        step();
        set_req(0, 1'b0, 10'h010, '0, '0);
        set_req(2, 1'b0, 10'h020, '0, '0);
        step();
        check("il_ack0", 64'(winner), 64'd0);
        step();
        check("il_ack2", 64'(winner), 64'd2);
        step();
        check("il_rv0", 64'(seen_rvalid), 64'b0001);
        check("il_rd0", 64'(seen_rdata), 64'h11);
        step();
        check("il_rv2", 64'(seen_rvalid), 64'b0100);
        check("il_rd2", 64'(seen_rdata), 64'h22);
        step();

        // Reset in the cycle after a read accept.
        set_req(2, 1'b0, 10'h005, '0, '0);
        step();
        check("mr_ack", 64'(winner), 64'd2);
        do_reset(2);
        for (int i = 0; i < 4; i++) begin
            step();
            check("mr_no_rvalid", 64'(seen_rvalid), 64'd0);
        end
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 10'h030, 32'h0, 4'h0);
        step();
        check("mr_first_m0", 64'(winner), 64'd0);

        // Randomized traffic on a small address window to provoke reuse.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!p_req[i] && $urandom_range(1, 0) == 1) begin
                    set_req(i, 1'($urandom_range(1, 0)), AW'($urandom_range(15, 0)),
                            $urandom, BW'($urandom_range(15, 0)));
                end
            end
            step();
        end
        clear_reqs();
        for (int i = 0; i < 4; i++) step();
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
